// File: rtl/irq_service_unit.sv
// CPU-side interrupt responder: offers a vector over valid/ready, pulses an ack to the
// source, and tracks the in-service line until EOI or timeout.
module irq_service_unit #(
   parameter logic [7:0] VECTOR_BASE = 8'h20,
   parameter logic [7:0] TIMEOUT     = 8'd200
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_int_valid,
   input  logic [1:0]  i_int_id,
   input  logic        i_cpu_ready,
   input  logic        i_eoi,
   input  logic        i_err_clr,
   output logic        o_vector_valid,
   output logic [7:0]  o_vector,
   output logic [3:0]  o_irq_ack,
   output logic [3:0]  o_in_service,
   output logic        o_busy,
   output logic        o_timeout_err,
   output logic [15:0] o_serviced_count
);

   typedef enum logic [1:0] {StIdle, StOffer, StService, StDone} state_e;

   state_e     r_state;
   logic [1:0] r_cur_id;
   logic [7:0] r_timer;

   logic [7:0] w_vector_next;
   logic [3:0] w_onehot;
   logic       w_timer_last;

   // ID 0 is the highest priority line and maps to bit 3.
   assign w_vector_next = VECTOR_BASE + {4'b0000, i_int_id, 2'b00};
   assign w_onehot      = 4'b1000 >> r_cur_id;
   assign w_timer_last  = (r_timer == (TIMEOUT - 8'd1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state          <= StIdle;
         r_cur_id         <= 2'd0;
         r_timer          <= 8'd0;
         o_vector_valid   <= 1'b0;
         o_vector         <= 8'd0;
         o_irq_ack        <= 4'd0;
         o_in_service     <= 4'd0;
         o_busy           <= 1'b0;
         o_timeout_err    <= 1'b0;
         o_serviced_count <= 16'd0;
      end else begin
         o_irq_ack <= 4'd0;
         // A timeout raised below on the same edge overrides this clear.
         if (i_err_clr) o_timeout_err <= 1'b0;

         case (r_state)
            StIdle: begin
               if (i_int_valid) begin
                  r_cur_id       <= i_int_id;
                  o_vector       <= w_vector_next;
                  o_vector_valid <= 1'b1;
                  o_busy         <= 1'b1;
                  r_state        <= StOffer;
               end
            end
            StOffer: begin
               if (i_cpu_ready) begin
                  o_vector_valid <= 1'b0;
                  o_irq_ack      <= w_onehot;
                  o_in_service   <= w_onehot;
                  r_timer        <= 8'd0;
                  r_state        <= StService;
               end
            end
            StService: begin
               r_timer <= r_timer + 8'd1;
               if (i_eoi) begin
                  o_in_service     <= 4'd0;
                  o_serviced_count <= o_serviced_count + 16'd1;
                  r_state          <= StDone;
               end else if (w_timer_last) begin
                  o_in_service  <= 4'd0;
                  o_timeout_err <= 1'b1;
                  o_busy        <= 1'b0;
                  r_state       <= StIdle;
               end
            end
            StDone: begin
               o_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               o_busy  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_service_unit.sv
// Directed bench for irq_service_unit: main instance with TIMEOUT=4, second instance
// with VECTOR_BASE=8'hFE for the vector wrap case.
module tb_irq_service_unit;

   logic        clk;
   logic        reset;
   logic        int_valid;
   logic [1:0]  int_id;
   logic        cpu_ready;
   logic        eoi;
   logic        err_clr;
   logic        vv;
   logic [7:0]  vec;
   logic [3:0]  ack;
   logic [3:0]  ins;
   logic        busy;
   logic        err;
   logic [15:0] cnt;

   logic        int_valid_w;
   logic [1:0]  int_id_w;
   logic        vv_w;
   logic [7:0]  vec_w;
   logic [3:0]  ack_w;
   logic [3:0]  ins_w;
   logic        busy_w;
   logic        err_w;
   logic [15:0] cnt_w;

   int n_total;
   int n_bad;
   int cyc;
   int ack_cyc;

   irq_service_unit #(.VECTOR_BASE(8'h20), .TIMEOUT(8'd4)) dut (
      .i_clk(clk), .i_reset(reset), .i_int_valid(int_valid), .i_int_id(int_id),
      .i_cpu_ready(cpu_ready), .i_eoi(eoi), .i_err_clr(err_clr),
      .o_vector_valid(vv), .o_vector(vec), .o_irq_ack(ack), .o_in_service(ins),
      .o_busy(busy), .o_timeout_err(err), .o_serviced_count(cnt)
   );

   irq_service_unit #(.VECTOR_BASE(8'hFE), .TIMEOUT(8'd200)) dut_w (
      .i_clk(clk), .i_reset(reset), .i_int_valid(int_valid_w), .i_int_id(int_id_w),
      .i_cpu_ready(1'b0), .i_eoi(1'b0), .i_err_clr(1'b0),
      .o_vector_valid(vv_w), .o_vector(vec_w), .o_irq_ack(ack_w), .o_in_service(ins_w),
      .o_busy(busy_w), .o_timeout_err(err_w), .o_serviced_count(cnt_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_vv"},   {31'd0, vv},   32'd0);
      check_eq({tag, "_vec"},  {24'd0, vec},  32'd0);
      check_eq({tag, "_ack"},  {28'd0, ack},  32'd0);
      check_eq({tag, "_ins"},  {28'd0, ins},  32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_err"},  {31'd0, err},  32'd0);
      check_eq({tag, "_cnt"},  {16'd0, cnt},  32'd0);
   endtask

   initial begin
      n_total = 0; n_bad = 0; cyc = 0; ack_cyc = 0;
      reset = 1'b0; int_valid = 1'b0; int_id = 2'd0; cpu_ready = 1'b0;
      eoi = 1'b0; err_clr = 1'b0; int_valid_w = 1'b0; int_id_w = 2'd0;
      #2 reset = 1'b1;
      tick();
      tick();
      check_all_zero("rst");
      reset = 1'b0;

      // Basic service, id 1
      int_id = 2'd1; int_valid = 1'b1; cpu_ready = 1'b1;
      tick();
      check_eq("basic_vv", {31'd0, vv}, 32'd1);
      check_eq("basic_vec", {24'd0, vec}, 32'h24);
      check_eq("basic_busy", {31'd0, busy}, 32'd1);
      int_valid = 1'b0;
      tick();
      check_eq("basic_ack", {28'd0, ack}, 32'b0100);
      check_eq("basic_ins", {28'd0, ins}, 32'b0100);
      check_eq("basic_vv_lo", {31'd0, vv}, 32'd0);
      tick();
      check_eq("basic_ack_once", {28'd0, ack}, 32'd0);
      check_eq("basic_ins2", {28'd0, ins}, 32'b0100);
      tick();
      check_eq("basic_ins3", {28'd0, ins}, 32'b0100);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check_eq("basic_ins_clr", {28'd0, ins}, 32'd0);
      check_eq("basic_cnt", {16'd0, cnt}, 32'd1);
      check_eq("basic_done_busy", {31'd0, busy}, 32'd1);
      tick();
      check_eq("basic_idle", {31'd0, busy}, 32'd0);

      // Backpressure, id 3, id change during OFFER ignored
      int_id = 2'd3; int_valid = 1'b1; cpu_ready = 1'b0;
      tick();
      int_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("bp_vv%0d", i), {31'd0, vv}, 32'd1);
         check_eq($sformatf("bp_vec%0d", i), {24'd0, vec}, 32'h2C);
         if (i == 2) begin
            int_id = 2'd0;
            int_valid = 1'b1;
         end
         tick();
      end
      check_eq("bp_vec_hold", {24'd0, vec}, 32'h2C);
      int_valid = 1'b0;
      cpu_ready = 1'b1;
      tick();
      check_eq("bp_ack", {28'd0, ack}, 32'b0001);
      check_eq("bp_ins", {28'd0, ins}, 32'b0001);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check_eq("bp_cnt", {16'd0, cnt}, 32'd2);
      tick();

      // Timeout, id 0, err_clr on the expiring edge loses to the set
      int_id = 2'd0; int_valid = 1'b1;
      tick();
      int_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("to_ins%0d", i), {28'd0, ins}, 32'b1000);
         check_eq($sformatf("to_err%0d", i), {31'd0, err}, 32'd0);
         if (i == 3) err_clr = 1'b1;
         tick();
      end
      err_clr = 1'b0;
      check_eq("to_ins_clr", {28'd0, ins}, 32'd0);
      check_eq("to_err_set", {31'd0, err}, 32'd1);
      check_eq("to_cnt", {16'd0, cnt}, 32'd2);
      check_eq("to_busy", {31'd0, busy}, 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_eq("to_err_clr", {31'd0, err}, 32'd0);

      // EOI on the expiring cycle wins over timeout
      int_valid = 1'b1;
      tick();
      int_valid = 1'b0;
      tick();
      tick();
      tick();
      tick();
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check_eq("race_cnt", {16'd0, cnt}, 32'd3);
      check_eq("race_err", {31'd0, err}, 32'd0);
      check_eq("race_busy", {31'd0, busy}, 32'd1);
      tick();

      // Vector wrap on the second instance
      int_id_w = 2'd1; int_valid_w = 1'b1;
      tick();
      int_valid_w = 1'b0;
      check_eq("wrap_vv", {31'd0, vv_w}, 32'd1);
      check_eq("wrap_vec", {24'd0, vec_w}, 32'h02);

      // Reset mid-SERVICE clears outputs before any clock edge
      int_id = 2'd2; int_valid = 1'b1;
      tick();
      int_valid = 1'b0;
      tick();
      check_eq("mid_ins", {28'd0, ins}, 32'b0010);
      #2 reset = 1'b1;
      #1;
      check_all_zero("mid_rst");
      tick();
      reset = 1'b0;
      tick();
      int_id = 2'd3; int_valid = 1'b1;
      tick();
      int_valid = 1'b0;
      check_eq("post_vec", {24'd0, vec}, 32'h2C);
      tick();
      check_eq("post_ack", {28'd0, ack}, 32'b0001);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check_eq("post_cnt", {16'd0, cnt}, 32'd1);
      tick();

      // Back-to-back with int_valid held, ids 3 then 0
      int_valid = 1'b1; int_id = 2'd3;
      tick();
      tick();
      check_eq("b2b_ack1", {28'd0, ack}, 32'b0001);
      ack_cyc = cyc;
      eoi = 1'b1; int_id = 2'd0;
      tick();
      eoi = 1'b0;
      tick();
      tick();
      check_eq("b2b_vec2", {24'd0, vec}, 32'h20);
      tick();
      check_eq("b2b_ack2", {28'd0, ack}, 32'b1000);
      check_eq("b2b_gap", cyc - ack_cyc, 32'd4);
      eoi = 1'b1; int_valid = 1'b0;
      tick();
      eoi = 1'b0;
      check_eq("b2b_cnt", {16'd0, cnt}, 32'd3);
      tick();

      // EOI in IDLE is ignored
      eoi = 1'b1;
      tick();
      tick();
      eoi = 1'b0;
      check_eq("idle_eoi_busy", {31'd0, busy}, 32'd0);
      check_eq("idle_eoi_cnt", {16'd0, cnt}, 32'd3);
      check_eq("idle_eoi_ins", {28'd0, ins}, 32'd0);
      check_eq("idle_eoi_ack", {28'd0, ack}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/irq_service_unit.md
# irq_service_unit

CPU-side responder for the 4-line priority interrupt controller. Consumes the controller's `int_valid`/`int_id` output and presents an interrupt vector to the CPU through a valid/ready handshake. Returns a one-cycle acknowledge pulse to the originating source and tracks the in-service line until end-of-interrupt (EOI) or timeout. Sits between `interrupt_controller` and the CPU core.

## Interface

**Parameters**

- `VECTOR_BASE`, default 8'h20: base of the vector table.
- `TIMEOUT`, default 8'd200: maximum SERVICE cycles without EOI. Legal range 1..255.

**Ports**

- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `int_valid` input 1: interrupt pending, from the controller.
- `int_id` input 2: winning interrupt ID, from the controller. 0 is the highest priority and maps to `irq[3]`.
- `cpu_ready` input 1: CPU accepts the vector.
- `eoi` input 1: CPU end-of-interrupt strobe.
- `err_clr` input 1: clears `timeout_err`.
- `vector_valid` output 1: vector offered to the CPU.
- `vector` output 8: interrupt vector.
- `irq_ack` output 4: one-hot acknowledge pulse to the source, same bit order as `irq`.
- `in_service` output 4: one-hot line currently being serviced.
- `busy` output 1: state is not IDLE.
- `timeout_err` output 1: sticky; set when service was aborted by timeout.
- `serviced_count` output 16: count of EOI-completed services.

## Operation

**State machine:** IDLE, OFFER, SERVICE, DONE.

- **IDLE**
  - `int_valid`=1 at the clock edge: latch `int_id` into `cur_id`, go to OFFER.
  - Otherwise stay in IDLE.
  - `eoi` is ignored.
- **OFFER**
  - `vector_valid`=1.
  - `vector` = (`VECTOR_BASE` + 4·`cur_id`) mod 256. 8-bit add, carry discarded.
  - `vector` is held stable while `vector_valid`=1.
  - `int_valid`/`int_id` changes are ignored in this state.
  - `vector_valid`&`cpu_ready` at the edge: go to SERVICE.
  - There is no timeout while waiting in OFFER.
- **SERVICE**
  - On entry, `irq_ack[3-cur_id]` pulses for exactly one cycle.
  - `in_service[3-cur_id]`=1 for the whole state.
  - An 8-bit timer clears on entry and increments each SERVICE cycle.
  - `eoi`=1: go to DONE.
  - Else, if timer == `TIMEOUT`-1: go to IDLE, set `timeout_err`, clear `in_service`. `serviced_count` is unchanged.
  - `eoi` and timeout expiring on the same edge: `eoi` wins, treated as normal completion.
- **DONE**
  - `in_service`=0.
  - `serviced_count` increments on entry. 16-bit, wraps 16'hFFFF to 0.
  - Unconditionally returns to IDLE next cycle.
  - `int_valid` is not sampled here.
- **`err_clr`:** clears `timeout_err` on any edge. A timeout set on the same edge has priority over the clear.
- **`busy`** = (state != IDLE).
- **Reset:** asynchronous, from any state.
  - State goes to IDLE.
  - All outputs go to 0: `vector`=0, `vector_valid`=0, `irq_ack`=0, `in_service`=0, `busy`=0, `timeout_err`=0, `serviced_count`=0.
  - `cur_id` and timer go to 0.

## Timing

- All outputs are registered; none is combinational from inputs.
- `int_valid` sampled at edge N (IDLE) → `vector_valid`=1 and `busy`=1 from N+1.
- Handshake at edge M → from M+1: `vector_valid`=0, `irq_ack` high for cycle M+1 only, `in_service` set.
- `eoi` at edge E (SERVICE) → from E+1: state DONE, `in_service`=0, `serviced_count`+1.
- E+2: IDLE. A new `int_valid` can be sampled at edge E+2.
- Minimum interrupt-to-interrupt turnaround with `cpu_ready` tied high: 4 cycles.
- Timeout: with no `eoi`, SERVICE lasts exactly `TIMEOUT` cycles. `timeout_err` rises and `in_service` falls on the cycle after the last SERVICE cycle.
- A `reset` pulse mid-SERVICE clears `in_service` immediately, without waiting for a clock edge, and generates no `irq_ack`.

## Test plan

- **Basic service:** `int_id`=2'd1, `int_valid`=1, `cpu_ready`=1, `eoi` 3 cycles later.
  - Required: `vector`=8'h24, `irq_ack`=4'b0100 for one cycle, `in_service`=4'b0100 until EOI, `serviced_count`=1.
- **Backpressure:** `int_id`=2'd3, `cpu_ready`=0 for 5 cycles, then 1.
  - Required: `vector_valid` held 5+ cycles with `vector`=8'h2C stable.
  - Required: `int_id` changing to 0 during OFFER leaves `vector` unchanged.
  - Required: ack pulse is 4'b0001.
- **Timeout:** `TIMEOUT`=4, `int_id`=0, no `eoi`.
  - Required: `in_service`=4'b1000 for exactly 4 cycles, then `timeout_err`=1, `serviced_count`=0.
  - Required: `err_clr` clears `timeout_err`.
  - `eoi` on the expiring cycle → `serviced_count`=1 and `timeout_err`=0.
- **Vector wrap:** `VECTOR_BASE`=8'hFE, `int_id`=2'd1 → `vector`=8'h02.
- **Reset mid-operation:** assert `reset` during SERVICE for `int_id`=2.
  - Required: all outputs 0 within the reset cycle.
  - Required: after release, `int_valid` with `int_id`=3 is serviced normally with `vector`=8'h2C.
- **Back-to-back with priority:** `int_valid` held high, `int_id` sequence 3→0, `cpu_ready`=1, immediate `eoi`.
  - Required: two services 4 cycles apart, acks 4'b0001 then 4'b1000, `serviced_count`=2.
  - Required: `eoi` pulsed while in IDLE changes nothing.
